// File: rtl/memory_writeback_phase_pkg.sv
// Shared pipeline definitions for the memory/writeback phase: FSM state
// encoding, the default memory-access timeout and a word-alignment helper.
package memory_writeback_phase_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mwb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

  // Word accesses only: the two address LSBs must be zero.
  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/memory_writeback_phase_access_timer.sv
// AccessTimer: counts ACCESS-state cycles. The count reads 1 in the first
// cycle mem_req is high, advances once per cycle while running, and raises
// expired when it reaches TIMEOUT_CYCLES. clear has priority over start.
module memory_writeback_phase_access_timer
  import memory_writeback_phase_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Load 1 on start, hold at the limit, return to 0 on clear or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(1);
    end else if (count != '0 && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/memory_writeback_phase.sv
// Memory/writeback phase of a simple in-order pipeline.
// ALU results are written back one cycle after ex_valid. Loads and stores
// move to ACCESS, where mem_req/mem_we/mem_addr/mem_wdata are held stable
// until mem_ack or the access timeout. stall is high for the whole ACCESS
// state and upstream holds its outputs meanwhile; ex_valid is ignored then.
// Handshake: a data-memory transfer completes in the cycle where mem_req
// and mem_ack are both high at the rising clock edge; mem_ack is ignored
// whenever mem_req is low.
module memory_writeback_phase
  import memory_writeback_phase_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ex_valid,
  input  logic [31:0] ALU_result,
  input  logic [4:0]  regdst,
  input  logic [31:0] store_data,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic        memtoreg,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        mem_err,
  output logic        dbg_state
);

  mwb_state_t  state;
  logic [4:0]  cap_reg;
  logic        cap_regwrite;
  logic        cap_memread;
  logic        cap_memtoreg;
  logic        mem_op;
  logic        acc_start;
  logic        acc_clear;
  logic        acc_expired;
  logic        load_wb;

  assign stall     = (state == ST_ACCESS);
  assign dbg_state = (state == ST_ACCESS);
  assign mem_op    = memread | memwrite;

  // An aligned memory op accepted in IDLE starts the timer; ack or expiry stops it.
  assign acc_start = (state == ST_IDLE) && ex_valid && mem_op && word_aligned(ALU_result[1:0]);
  assign acc_clear = (state == ST_ACCESS) && (mem_ack || acc_expired);

  // Only a pure load with a nonzero destination writes back after ack.
  assign load_wb = cap_memread && !mem_we && cap_regwrite && (cap_reg != 5'd0);

  memory_writeback_phase_access_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access_timer (
    .clk     (Clk),
    .rst     (Rst),
    .start   (acc_start),
    .clear   (acc_clear),
    .expired (acc_expired)
  );

  // Phase FSM with registered memory-port and writeback outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= ST_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wb_en        <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      mem_err      <= 1'b0;
      cap_reg      <= '0;
      cap_regwrite <= 1'b0;
      cap_memread  <= 1'b0;
      cap_memtoreg <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (mem_op) begin
              if (acc_start) begin
                state        <= ST_ACCESS;
                mem_req      <= 1'b1;
                mem_we       <= memwrite;
                mem_addr     <= ALU_result;
                mem_wdata    <= store_data;
                cap_reg      <= regdst;
                cap_regwrite <= regwrite;
                cap_memread  <= memread;
                cap_memtoreg <= memtoreg;
              end else begin
                mem_err <= 1'b1;
              end
            end else if (regwrite && regdst != 5'd0) begin
              wb_en   <= 1'b1;
              wb_reg  <= regdst;
              wb_data <= ALU_result;
            end
          end
        end
        ST_ACCESS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack || acc_expired) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (mem_ack) begin
              if (load_wb) begin
                wb_en   <= 1'b1;
                wb_reg  <= cap_reg;
                wb_data <= cap_memtoreg ? mem_rdata : mem_addr;
              end
            end else begin
              mem_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writeback_phase.sv
// Directed bench for memory_writeback_phase. Stimulus tasks push expected
// writeback / error pulses into exp_q; a negedge monitor pops and compares
// whenever wb_en or mem_err is seen.
module tb_memory_writeback_phase;

  localparam int TO = 15;

  logic        Clk;
  logic        Rst;
  logic        ex_valid;
  logic [31:0] ALU_result;
  logic [4:0]  regdst;
  logic [31:0] store_data;
  logic        memread, memwrite, regwrite, memtoreg;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mem_err;
  logic        dbg_state;

  // Entry layout: {is_err, reg[4:0], data[31:0]}
  logic [37:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  memory_writeback_phase #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ex_valid   (ex_valid),
    .ALU_result (ALU_result),
    .regdst     (regdst),
    .store_data (store_data),
    .memread    (memread),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .mem_err    (mem_err),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    logic [37:0] e;
    if (wb_en || mem_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: wb_en=%0b mem_err=%0b wb_reg=%0d wb_data=%h, required no output",
                 wb_en, mem_err, wb_reg, wb_data);
      end else begin
        e = exp_q.pop_front();
        check("out_is_err", 32'(mem_err), 32'(e[37]));
        if (e[37]) begin
          check("err_no_wb", 32'(wb_en), 32'd0);
        end else begin
          check("wb_en", 32'(wb_en), 32'd1);
          check("wb_reg", 32'(wb_reg), 32'(e[36:32]));
          check("wb_data", wb_data, e[31:0]);
        end
      end
    end
  end

  task automatic clear_inputs();
    ex_valid   = 1'b0;
    ALU_result = '0;
    regdst     = '0;
    store_data = '0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
  endtask

  task automatic issue_alu(input logic [31:0] res, input logic [4:0] rd, input logic rw);
    ex_valid   = 1'b1;
    ALU_result = res;
    regdst     = rd;
    regwrite   = rw;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    if (rw && rd != 5'd0) exp_q.push_back({1'b0, rd, res});
    tick();
    ex_valid = 1'b0;
    check("alu_stall", 32'(stall), 32'd0);
  endtask

  // Memory op; ack_after = mem_req cycle carrying mem_ack (0 = never ack).
  // While stalled, a conflicting ALU op is driven on ex_valid and must be ignored.
  task automatic mem_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic is_wr, input logic rw,
                        input logic mtr, input int ack_after, input logic [31:0] rdata);
    int  stall_cycles;
    int  exp_stall;
    bit  done;
    ex_valid   = 1'b1;
    ALU_result = addr;
    store_data = wdata;
    regdst     = rd;
    memread    = !is_wr;
    memwrite   = is_wr;
    regwrite   = rw;
    memtoreg   = mtr;
    if (addr[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, 5'd0, 32'd0});
      tick();
      clear_inputs();
      check("misalign_req", 32'(mem_req), 32'd0);
      check("misalign_stall", 32'(stall), 32'd0);
      tick();
      check("misalign_req_after", 32'(mem_req), 32'd0);
      return;
    end
    tick();
    ex_valid   = 1'b1;
    ALU_result = 32'h0000_0077;
    regdst     = 5'd3;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b1;
    memtoreg   = 1'b0;
    store_data = 32'h0000_0099;
    stall_cycles = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= TO && !done; cyc++) begin
      check("acc_req", 32'(mem_req), 32'd1);
      check("acc_stall", 32'(stall), 32'd1);
      check("acc_we", 32'(mem_we), 32'(is_wr));
      check("acc_addr", mem_addr, addr);
      check("acc_wdata", mem_wdata, wdata);
      stall_cycles++;
      if (cyc == ack_after) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        if (!is_wr && rw && rd != 5'd0) exp_q.push_back({1'b0, rd, mtr ? rdata : addr});
        done = 1'b1;
      end else if (cyc == TO) begin
        exp_q.push_back({1'b1, 5'd0, 32'd0});
        done = 1'b1;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_0000;
    end
    clear_inputs();
    exp_stall = (ack_after >= 1 && ack_after <= TO) ? ack_after : TO;
    check("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
    check("post_req", 32'(mem_req), 32'd0);
    check("post_stall", 32'(stall), 32'd0);
    check("post_state", 32'(dbg_state), 32'd0);
    check("post_we", 32'(mem_we), 32'd0);
  endtask

  // Directed sequence
  initial begin
    Rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0_0000;
    clear_inputs();
    tick();
    tick();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_reg", 32'(wb_reg), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    Rst = 1'b0;

    // ALU ops: basic, suppressed destination 0, no regwrite, back-to-back
    issue_alu(32'h0000_002A, 5'd8, 1'b1);
    issue_alu(32'h1111_1111, 5'd0, 1'b1);
    issue_alu(32'h2222_2222, 5'd6, 1'b0);
    issue_alu(32'hA5A5_0001, 5'd1, 1'b1);
    issue_alu(32'hFFFF_FFFF, 5'd31, 1'b1);
    tick();

    // Load 0x100 acked in the 3rd mem_req cycle
    mem_op(32'h0000_0100, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    // Store 0x104, data 0x55, acked in cycle 2; no writeback
    mem_op(32'h0000_0104, 32'h0000_0055, 5'd10, 1'b1, 1'b0, 1'b0, 2, 32'h1234_5678);
    // Misaligned load and store
    mem_op(32'h0000_0102, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1, 32'h0);
    mem_op(32'h0000_0107, 32'h0000_00AA, 5'd9, 1'b1, 1'b0, 1'b0, 1, 32'h0);
    // Timeout with no ack, then ack exactly on cycle 15
    mem_op(32'h0000_0200, 32'h0, 5'd11, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    mem_op(32'h0000_0300, 32'h0, 5'd12, 1'b0, 1'b1, 1'b1, TO, 32'hCAFE_F00D);
    // Load with memtoreg=0 writes the address; load to r0 writes nothing
    mem_op(32'h0000_0040, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1, 32'h0BAD_0BAD);
    mem_op(32'h0000_0044, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 2, 32'h7777_7777);

    // mem_ack while idle has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_req", 32'(mem_req), 32'd0);
    check("idle_ack_stall", 32'(stall), 32'd0);

    // Reset in the middle of an access
    ex_valid   = 1'b1;
    ALU_result = 32'h0000_0180;
    regdst     = 5'd7;
    memread    = 1'b1;
    regwrite   = 1'b1;
    memtoreg   = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("mid_req", 32'(mem_req), 32'd1);
    Rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    tick();
    // Release: first rising edge must accept a new op; a stray ack is ignored
    Rst     = 1'b0;
    mem_ack = 1'b1;
    issue_alu(32'h0000_1234, 5'd4, 1'b1);
    mem_ack = 1'b0;
    check("rel_req", 32'(mem_req), 32'd0);
    tick();
    tick();
    tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_writeback_phase.md
MEMORY_WRITEBACK_PHASE -- requirements
Module: memory_writeback_phase

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum ACCESS-state cycles to wait for mem_ack.
REQ-002 SHALL have port Clk  input  1  single clock, rising edge.
REQ-003 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ex_valid  input  1  execute-phase outputs valid this cycle.
REQ-005 SHALL have port ALU_result  input  32  ALU result / memory address from execute.
REQ-006 SHALL have port regdst  input  5  destination register from execute.
REQ-007 SHALL have port store_data  input  32  rt data for stores.
REQ-008 SHALL have port memread, memwrite, regwrite, memtoreg  input  1 each  control bits from execute.
REQ-009 SHALL have port stall  output  1  hold-upstream request.
REQ-010 SHALL have port mem_req, mem_we  output  1 each  data-memory request and write enable.
REQ-011 SHALL have port mem_addr, mem_wdata  output  32 each  data-memory address and write data.
REQ-012 SHALL have port mem_rdata  input  32 and mem_ack  input  1  memory read data and completion.
REQ-013 SHALL have port wb_en  output  1, wb_reg  output  5, wb_data  output  32  register-file write port.
REQ-014 SHALL have port mem_err  output  1  one-cycle misalign/timeout pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS; stall = (state == ACCESS), combinational.
REQ-016 SHALL, in IDLE with ex_valid and no mem op: register result; wb_en = regwrite, wb_data = ALU_result, wb_reg = regdst next cycle (latency 1, one op per cycle, no stall).
REQ-017 SHALL, in IDLE with ex_valid and memread or memwrite and ALU_result[1:0] == 0: capture address, store_data, regdst and control bits; go to ACCESS; mem_req = 1 from next cycle.
REQ-018 SHALL hold mem_req, mem_we (= captured memwrite), mem_addr and mem_wdata stable throughout ACCESS until mem_ack is sampled high.
REQ-019 SHALL, on mem_ack in ACCESS: drop mem_req next cycle, return to IDLE; for a load with regwrite, assert wb_en next cycle with wb_data = mem_rdata sampled at ack (memtoreg = 1) or captured ALU_result (memtoreg = 0); no writeback for a store.
REQ-020 SHALL ignore ex_valid while stall is high; upstream holds its outputs.
REQ-021 SHALL, for a mem op with ALU_result[1:0] != 0: issue no mem_req, write nothing back, pulse mem_err next cycle, stay in IDLE.
REQ-022 SHALL count ACCESS cycles, starting at 1 on the first mem_req cycle; at count == TIMEOUT_CYCLES without ack: drop mem_req, pulse mem_err, return to IDLE, write nothing back.
REQ-023 SHALL give mem_ack priority when it arrives in the same cycle as timeout.
REQ-024 SHALL suppress wb_en when wb_reg == 0.
REQ-025 SHALL ignore mem_ack while in IDLE.
REQ-026 SHALL keep wb_en and mem_err as single-cycle pulses, low in all other cycles.

Reset
REQ-027 SHALL, on Rst high, immediately force state IDLE, counter 0, and all outputs 0 (stall, mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_reg, wb_data, mem_err), including mid-ACCESS.
REQ-028 SHALL resume accepting ex_valid on the first rising Clk after Rst deasserts.

Structure
REQ-029 SHALL take the FSM state encoding and a default TIMEOUT constant from the shared pipeline package.
REQ-030 SHALL place the ACCESS timeout counter in one sub-module, AccessTimer (start, clear, expired).

Verification
REQ-031 SHALL check ALU op: ex_valid, ALU_result=0x0000002A, regdst=8, regwrite=1 -> next cycle wb_en=1, wb_reg=8, wb_data=0x2A, stall=0.
REQ-032 SHALL check load: addr 0x100, mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> stall high 3 cycles, wb_en=1 with 0xDEADBEEF the cycle after ack.
REQ-033 SHALL check store: addr 0x104, store_data 0x55 -> mem_we=1, mem_wdata=0x55 held until ack, wb_en never asserted.
REQ-034 SHALL check misaligned load at 0x102 -> mem_req stays 0, mem_err pulses once, wb_en stays 0.
REQ-035 SHALL check timeout: no ack, TIMEOUT_CYCLES=15 -> mem_req high 15 cycles, then mem_err pulse, state IDLE, stall 0; ack on cycle 15 -> normal writeback.
REQ-036 SHALL check Rst asserted mid-ACCESS -> mem_req and stall 0 immediately, no wb_en after release.
